fifo_result_drain: RTL and testbench
====================================

Name: fifo_result_drain

Overview:
- Read-side consumer of the 12-bit result FIFO filled by data_path.
- Pops words whenever the FIFO is non-empty, groups GROUP_LEN consecutive words, and computes the group sum and group maximum.
- Presents each group result downstream on a valid/ready handshake.
- Lets downstream logic (result write-back, host readout) consume FIFO contents without handling rd_en timing or FIFO read latency.

Parameters:
- DATA_W, 12, FIFO word width.
- GROUP_LEN, 4, words per group; must be ≥ 2.
- RD_LATENCY, 1, cycles from rd_en high to valid fifo_dout; legal values 1 or 2.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO pop request.
- fifo_dout  in  DATA_W  FIFO read data, valid RD_LATENCY cycles after the pop.
- flush  in  1  single-cycle pulse: close the current partial group.
- res_valid  out  1  group result valid.
- res_ready  in  1  downstream accepts the result.
- res_sum  out  DATA_W+$clog2(GROUP_LEN)  sum of the group's words, unsigned.
- res_max  out  DATA_W  maximum word in the group, unsigned.
- res_count  out  $clog2(GROUP_LEN+1)  number of words in the group.
- busy  out  1  high in any state other than IDLE/COLLECT-with-zero-words.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - State goes to COLLECT.
  - fifo_rd_en=0, res_valid=0, res_sum=0, res_max=0, res_count=0, busy=0.
  - Issued, received and in-flight counters clear to 0.
  - Data returning from pops made before reset is discarded.
  - Reset mid-group drops the partial group silently.
- fifo_rd_en is combinational: high iff all of the following hold:
  - state==COLLECT,
  - fifo_empty==0,
  - issued<GROUP_LEN,
  - no flush pending,
  - rst==0.
  - Back-to-back pops are allowed: one word per cycle.
- Read-valid tracking:
  - A RD_LATENCY-deep shift register carries each pop.
  - fifo_dout is sampled when the register's tail bit is 1.
- Accumulation on each sampled word:
  - sum += word, zero-extended to the sum width.
  - max = max(max, word).
  - received++.
  - The first word of a group loads sum and max directly rather than accumulating.
- States:
  - COLLECT: issue pops and accumulate. Go to DRAIN when issued==GROUP_LEN, or when flush is pending and issued>0.
  - DRAIN: no pops. Wait until received==issued (in-flight==0), then latch res_sum/res_max/res_count=received, set res_valid=1, go to OUT.
  - OUT: res_valid and all res_* are held stable until res_ready=1. On the accept edge: res_valid=0, counters clear, go to COLLECT.
- Output timing:
  - The last word returns at cycle t. res_valid rises at t+1 (registered).
  - Minimum group period is GROUP_LEN+RD_LATENCY+1 cycles when res_ready is tied high.
- res_valid and res_ready: res_ready may be high before res_valid; the transfer occurs on the first edge where both are 1.
- Flush:
  - A pulse in any state sets flush_pending; it is cleared when the resulting group is accepted.
  - Flush with issued==0 in COLLECT is cleared immediately and produces no output.
  - Flush in OUT applies to the next group, which then closes as soon as it has ≥1 word.
- Simultaneous flush and pop in the same cycle: the pop completes and is counted in the flushed group.
- fifo_empty rising while a pop is in flight has no effect; the in-flight data is still captured.
- Overflow is impossible: GROUP_LEN·(2^DATA_W−1) fits the sum width.

Optional Feature:
- Macro DRAIN_STATS_EN.
- When defined, two extra outputs are added:
  - stat_words (32 bits): total words received.
  - stat_groups (16 bits): total groups accepted.
  - Both clear on rst and wrap modulo 2^N.
  - stat_words increments on each sampled word.
  - stat_groups increments on each res_valid&&res_ready.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package acc_pkg holds:
  - the state enum DRAIN_ST_COLLECT/DRAIN/OUT,
  - DATA_W default 12,
  - the SUM_W function (DATA_W+$clog2(GROUP_LEN)).
- One natural sub-module: rd_latency_pipe, a parameterised valid shift register of depth RD_LATENCY with synchronous clear.
- The accumulator and FSM stay in the top module.

Test Plan:
- GROUP_LEN=4, FIFO preloaded 0x001,0x002,0xFFF,0x010; res_ready=1 → exactly 4 consecutive rd_en cycles; res_sum=0x1012, res_max=0xFFF, res_count=4; res_valid rises 1 cycle after the 4th word is sampled.
- Backpressure: hold res_ready=0 for 10 cycles with 8 words queued → fifo_rd_en stays 0 after 4 pops; res_* stable throughout; after accept, the second group is 4 more pops with correct sum.
- Flush after 2 words (0x100,0x200) and empty FIFO → res_count=2, res_sum=0x300, res_max=0x200; flush with 0 words → no res_valid for 20 cycles.
- Assert rst after 3 words → all outputs 0 next cycle; post-reset 4 words 0x005 ×4 → res_sum=0x014 (no stale data).
- fifo_empty toggling every other cycle, RD_LATENCY=2 → every word is captured exactly once; sum matches the scoreboard over 50 random groups.
- DRAIN_STATS_EN defined, 3 groups of 4 → stat_words=12, stat_groups=3.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types and sizing helpers for the result-FIFO drain block.
package acc_pkg;

    typedef enum logic [1:0] {
        DRAIN_ST_COLLECT = 2'd0,
        DRAIN_ST_DRAIN   = 2'd1,
        DRAIN_ST_OUT     = 2'd2
    } drain_state_e;

    localparam int DATA_W = 12;

    // Sum width large enough that GROUP_LEN full-scale words can never overflow.
    function automatic int SUM_W(input int data_w, input int group_len);
        return data_w + $clog2(group_len);
    endfunction

endpackage

// File: rtl/fifo_result_drain_if.sv
// FIFO read port and result handshake of the drain block; master is the drain side.
interface fifo_result_drain_if #(
    parameter int DATA_W    = acc_pkg::DATA_W,
    parameter int GROUP_LEN = 4
);
    localparam int SUM_BITS = acc_pkg::SUM_W(DATA_W, GROUP_LEN);
    localparam int CNT_W    = $clog2(GROUP_LEN + 1);

    logic                fifo_empty;
    logic                fifo_rd_en;
    logic [DATA_W-1:0]   fifo_dout;
    logic                res_valid;
    logic                res_ready;
    logic [SUM_BITS-1:0] res_sum;
    logic [DATA_W-1:0]   res_max;
    logic [CNT_W-1:0]    res_count;

    modport master (
        input  fifo_empty, fifo_dout, res_ready,
        output fifo_rd_en, res_valid, res_sum, res_max, res_count
    );

    modport slave (
        output fifo_empty, fifo_dout, res_ready,
        input  fifo_rd_en, res_valid, res_sum, res_max, res_count
    );

endinterface

// File: rtl/rd_latency_pipe.sv
// Valid shift register that tracks each FIFO pop until its data appears on fifo_dout.
module rd_latency_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic clr,
    input  logic in_valid,
    output logic out_valid
);

    logic [DEPTH-1:0] sr;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (clr) sr <= '0;
                else     sr <= in_valid;
            end
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (clr) sr <= '0;
                else     sr <= {sr[DEPTH-2:0], in_valid};
            end
        end
    endgenerate

    assign out_valid = sr[DEPTH-1];

endmodule

// File: rtl/fifo_result_drain.sv
// Result FIFO consumer: pops words, groups GROUP_LEN of them, presents sum/max/count downstream.
// Define DRAIN_STATS_EN to add the stat_words / stat_groups counters.
//
// state   | meaning
// COLLECT | issue pops while room in group, accumulate returning words
// DRAIN   | group closed, waiting for in-flight words to return
// OUT     | result presented, held until res_ready
module fifo_result_drain
    import acc_pkg::*;
#(
    parameter int DATA_W     = acc_pkg::DATA_W,
    parameter int GROUP_LEN  = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    fifo_result_drain_if.master bus,
    input  logic                flush,
    output logic                busy
`ifdef DRAIN_STATS_EN
    ,
    output logic [31:0]         stat_words,
    output logic [15:0]         stat_groups
`endif
);

    localparam int SUM_BITS = SUM_W(DATA_W, GROUP_LEN);
    localparam int CNT_W    = $clog2(GROUP_LEN + 1);
    localparam logic [CNT_W-1:0] GL_CNT = CNT_W'(GROUP_LEN);

    drain_state_e state, state_nxt;

    logic [CNT_W-1:0]    issued, received, rcv_nxt;
    logic [SUM_BITS-1:0] acc_sum, sum_nxt, res_sum_q;
    logic [DATA_W-1:0]   acc_max, max_nxt, res_max_q;
    logic [CNT_W-1:0]    res_count_q;
    logic                flush_pending, flush_carry;
    logic                pop, sample, accept, closing, complete;

    // A pending flush only blocks pops once the group holds a word, so a flush carried
    // over from OUT still lets the next group collect its first word.
    assign pop = (state == DRAIN_ST_COLLECT) && !bus.fifo_empty && (issued < GL_CNT)
                 && !(flush_pending && (issued != '0)) && !rst;

    rd_latency_pipe #(.DEPTH(RD_LATENCY)) u_rd_pipe (
        .clk       (clk),
        .clr       (rst),
        .in_valid  (pop),
        .out_valid (sample)
    );

    assign rcv_nxt = received + CNT_W'(sample);
    assign sum_nxt = !sample ? acc_sum
                   : (received == '0) ? SUM_BITS'(bus.fifo_dout)
                   : acc_sum + SUM_BITS'(bus.fifo_dout);
    assign max_nxt = !sample ? acc_max
                   : ((received == '0) || (bus.fifo_dout > acc_max)) ? bus.fifo_dout
                   : acc_max;

    assign closing  = ((state == DRAIN_ST_COLLECT) &&
                       ((issued == GL_CNT) || (flush_pending && (issued != '0))))
                      || (state == DRAIN_ST_DRAIN);
    // Result is latched on the edge that samples the last word, so res_valid follows one cycle later.
    assign complete = closing && (rcv_nxt == issued);
    assign accept   = (state == DRAIN_ST_OUT) && bus.res_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= DRAIN_ST_COLLECT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DRAIN_ST_COLLECT: begin
                if (complete)     state_nxt = DRAIN_ST_OUT;
                else if (closing) state_nxt = DRAIN_ST_DRAIN;
            end
            DRAIN_ST_DRAIN: begin
                if (complete) state_nxt = DRAIN_ST_OUT;
            end
            DRAIN_ST_OUT: begin
                if (accept) state_nxt = DRAIN_ST_COLLECT;
            end
            default: state_nxt = DRAIN_ST_COLLECT;
        endcase
    end

    always_comb begin
        bus.fifo_rd_en = pop;
        bus.res_valid  = (state == DRAIN_ST_OUT);
        busy           = !((state == DRAIN_ST_COLLECT) && (issued == '0));
    end

    assign bus.res_sum   = res_sum_q;
    assign bus.res_max   = res_max_q;
    assign bus.res_count = res_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            issued        <= '0;
            received      <= '0;
            acc_sum       <= '0;
            acc_max       <= '0;
            res_sum_q     <= '0;
            res_max_q     <= '0;
            res_count_q   <= '0;
            flush_pending <= 1'b0;
            flush_carry   <= 1'b0;
        end else begin
            if (accept) begin
                issued        <= '0;
                received      <= '0;
                acc_sum       <= '0;
                acc_max       <= '0;
                flush_pending <= flush_carry | flush;
                flush_carry   <= 1'b0;
            end else begin
                issued   <= issued + CNT_W'(pop);
                received <= rcv_nxt;
                acc_sum  <= sum_nxt;
                acc_max  <= max_nxt;
                // A flush seen while a result is on offer belongs to the following group.
                if (flush) begin
                    if (state == DRAIN_ST_OUT)
                        flush_carry <= 1'b1;
                    else if ((state != DRAIN_ST_COLLECT) || (issued != '0) || pop)
                        flush_pending <= 1'b1;
                end
            end
            if (complete) begin
                res_sum_q   <= sum_nxt;
                res_max_q   <= max_nxt;
                res_count_q <= rcv_nxt;
            end
        end
    end

`ifdef DRAIN_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_words  <= '0;
            stat_groups <= '0;
        end else begin
            if (sample) stat_words  <= stat_words + 32'd1;
            if (accept) stat_groups <= stat_groups + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_result_drain.sv
// Directed bench for fifo_result_drain: instance A (RD_LATENCY=1) for timing, backpressure,
// flush and reset; instance B (RD_LATENCY=2) with a toggling empty flag against a scoreboard.
module tb_fifo_result_drain;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_result_drain_if #(.DATA_W(12), .GROUP_LEN(4)) ifa ();
    fifo_result_drain_if #(.DATA_W(12), .GROUP_LEN(4)) ifb ();

    logic flush_a = 1'b0;
    logic flush_b = 1'b0;
    logic busy_a, busy_b;
`ifdef DRAIN_STATS_EN
    logic [31:0] stat_words_a, stat_words_b;
    logic [15:0] stat_groups_a, stat_groups_b;
`endif

    fifo_result_drain #(.DATA_W(12), .GROUP_LEN(4), .RD_LATENCY(1)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa), .flush (flush_a), .busy (busy_a)
`ifdef DRAIN_STATS_EN
        , .stat_words (stat_words_a), .stat_groups (stat_groups_a)
`endif
    );

    fifo_result_drain #(.DATA_W(12), .GROUP_LEN(4), .RD_LATENCY(2)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb), .flush (flush_b), .busy (busy_b)
`ifdef DRAIN_STATS_EN
        , .stat_words (stat_words_b), .stat_groups (stat_groups_b)
`endif
    );

    // FIFO models: one push per cycle from the bench, pops on rd_en with the given read latency
    logic [11:0] q_a[$];
    logic [11:0] q_b[$];
    logic        push_a = 1'b0, push_b = 1'b0, hold_a = 1'b1, tog_b = 1'b0;
    logic [11:0] pdata_a = '0, pdata_b = '0, d1_b = '0;
    int          cnt_a = 0, cnt_b = 0, pops_a = 0, pops_b = 0, underflow_a = 0, underflow_b = 0;

    assign ifa.fifo_empty = (cnt_a == 0) || hold_a;
    assign ifb.fifo_empty = (cnt_b == 0) || tog_b;

    always @(posedge clk) begin
        if (push_a) q_a.push_back(pdata_a);
        if (ifa.fifo_rd_en) begin
            if (q_a.size() == 0) underflow_a <= underflow_a + 1;
            else ifa.fifo_dout <= q_a.pop_front();
            pops_a <= pops_a + 1;
        end
        cnt_a <= q_a.size();
    end

    always @(posedge clk) begin
        tog_b <= ~tog_b;
        if (push_b) q_b.push_back(pdata_b);
        if (ifb.fifo_rd_en) begin
            if (q_b.size() == 0) underflow_b <= underflow_b + 1;
            else d1_b <= q_b.pop_front();
            pops_b <= pops_b + 1;
        end
        ifb.fifo_dout <= d1_b;
        cnt_b <= q_b.size();
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_word_a(input logic [11:0] w);
        pdata_a = w;
        push_a  = 1'b1;
        @(negedge clk);
        push_a  = 1'b0;
    endtask

    task automatic wait_valid_a(input logic lvl, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ifa.res_valid === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_group_a(input string tag, input logic [11:0] w0, input logic [11:0] w1,
                               input logic [11:0] w2, input logic [11:0] w3,
                               input logic [13:0] es, input logic [11:0] em);
        bit ok;
        hold_a = 1'b1;
        push_word_a(w0);
        push_word_a(w1);
        push_word_a(w2);
        push_word_a(w3);
        hold_a = 1'b0;
        wait_valid_a(1'b1, 20, ok);
        check_eq({tag, "_valid"}, 32'(ok), 32'd1);
        check_eq({tag, "_sum"},   32'(ifa.res_sum),   32'(es));
        check_eq({tag, "_max"},   32'(ifa.res_max),   32'(em));
        check_eq({tag, "_count"}, 32'(ifa.res_count), 32'd4);
        wait_valid_a(1'b0, 5, ok);
        check_eq({tag, "_accept"}, 32'(ok), 32'd1);
    endtask

    logic [13:0] exp_sum_b[$];
    logic [11:0] exp_max_b[$];
    int          n_res_b = 0;

    initial begin
        bit          ok;
        int          first_rd, last_rd, valid_at, n_rd, n_valid, unstable, base;
        logic [13:0] cap_sum;
        logic [11:0] cap_max;
        logic [2:0]  cap_cnt;

        ifa.res_ready = 1'b0;
        ifb.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_rd_en",  32'(ifa.fifo_rd_en), 32'd0);
        check_eq("rst_valid",  32'(ifa.res_valid),  32'd0);
        check_eq("rst_sum",    32'(ifa.res_sum),    32'd0);
        check_eq("rst_max",    32'(ifa.res_max),    32'd0);
        check_eq("rst_count",  32'(ifa.res_count),  32'd0);
        check_eq("rst_busy",   32'(busy_a),         32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Group timing: four back-to-back pops, result one cycle after last word returns
        push_word_a(12'h001);
        push_word_a(12'h002);
        push_word_a(12'hFFF);
        push_word_a(12'h010);
        ifa.res_ready = 1'b1;
        hold_a = 1'b0;
        first_rd = -1; last_rd = -1; valid_at = -1; n_rd = 0; n_valid = 0;
        cap_sum = '0; cap_max = '0; cap_cnt = '0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (ifa.fifo_rd_en) begin
                n_rd++;
                if (first_rd < 0) first_rd = i;
                last_rd = i;
            end
            if (ifa.res_valid) begin
                n_valid++;
                if (valid_at < 0) begin
                    valid_at = i;
                    cap_sum = ifa.res_sum; cap_max = ifa.res_max; cap_cnt = ifa.res_count;
                end
            end
            @(negedge clk);
        end
        check_eq("t1_rd_count",   32'(n_rd), 32'd4);
        check_eq("t1_rd_span",    32'(last_rd - first_rd), 32'd3);
        check_eq("t1_valid_lat",  32'(valid_at - first_rd), 32'd5);
        check_eq("t1_valid_once", 32'(n_valid), 32'd1);
        check_eq("t1_sum",   32'(cap_sum), 32'h1012);
        check_eq("t1_max",   32'(cap_max), 32'hFFF);
        check_eq("t1_count", 32'(cap_cnt), 32'd4);

        // Backpressure: 8 words queued, downstream stalled
        ifa.res_ready = 1'b0;
        hold_a = 1'b1;
        push_word_a(12'h011); push_word_a(12'h022); push_word_a(12'h033); push_word_a(12'h044);
        push_word_a(12'h100); push_word_a(12'h0FF); push_word_a(12'h800); push_word_a(12'h7FF);
        hold_a = 1'b0;
        base = pops_a; valid_at = -1; unstable = 0;
        for (int i = 0; i < 14; i++) begin
            #1;
            if (ifa.res_valid) begin
                if (valid_at < 0) begin
                    valid_at = i;
                    cap_sum = ifa.res_sum; cap_max = ifa.res_max; cap_cnt = ifa.res_count;
                end else if (ifa.res_sum !== cap_sum || ifa.res_max !== cap_max ||
                             ifa.res_count !== cap_cnt) begin
                    unstable++;
                end
            end
            @(negedge clk);
        end
        check_eq("t2_pops_stalled", 32'(pops_a - base), 32'd4);
        check_eq("t2_valid_at",     32'(valid_at), 32'd5);
        check_eq("t2_stable",       32'(unstable), 32'd0);
        check_eq("t2_g1_sum",   32'(cap_sum), 32'h0AA);
        check_eq("t2_g1_max",   32'(cap_max), 32'h044);
        check_eq("t2_g1_count", 32'(cap_cnt), 32'd4);
        ifa.res_ready = 1'b1;
        wait_valid_a(1'b0, 5, ok);
        check_eq("t2_g1_accept", 32'(ok), 32'd1);
        wait_valid_a(1'b1, 20, ok);
        check_eq("t2_g2_valid", 32'(ok), 32'd1);
        check_eq("t2_g2_sum",   32'(ifa.res_sum), 32'h11FE);
        check_eq("t2_g2_max",   32'(ifa.res_max), 32'h800);
        check_eq("t2_g2_count", 32'(ifa.res_count), 32'd4);
        wait_valid_a(1'b0, 5, ok);
        check_eq("t2_pops_total", 32'(pops_a - base), 32'd8);

        // Flush of a partial group, then a flush with nothing collected
        push_word_a(12'h100);
        push_word_a(12'h200);
        repeat (6) @(negedge clk);
        check_eq("t3_no_early_valid", 32'(ifa.res_valid), 32'd0);
        check_eq("t3_busy_partial",   32'(busy_a), 32'd1);
        flush_a = 1'b1;
        @(negedge clk);
        flush_a = 1'b0;
        wait_valid_a(1'b1, 10, ok);
        check_eq("t3_flush_valid", 32'(ok), 32'd1);
        check_eq("t3_flush_sum",   32'(ifa.res_sum), 32'h300);
        check_eq("t3_flush_max",   32'(ifa.res_max), 32'h200);
        check_eq("t3_flush_count", 32'(ifa.res_count), 32'd2);
        repeat (2) @(negedge clk);
        flush_a = 1'b1;
        @(negedge clk);
        flush_a = 1'b0;
        n_valid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifa.res_valid) n_valid++;
        end
        check_eq("t3_empty_flush_quiet", 32'(n_valid), 32'd0);
        check_eq("t3_idle_busy",         32'(busy_a), 32'd0);

        // Reset mid-group with the third word still returning
        hold_a = 1'b1;
        push_word_a(12'h0AA);
        push_word_a(12'h0BB);
        push_word_a(12'h0CC);
        hold_a = 1'b0;
        base = pops_a;
        repeat (3) @(negedge clk);
        check_eq("t4_pops_before_rst", 32'(pops_a - base), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t4_rst_rd_en", 32'(ifa.fifo_rd_en), 32'd0);
        check_eq("t4_rst_valid", 32'(ifa.res_valid), 32'd0);
        check_eq("t4_rst_sum",   32'(ifa.res_sum), 32'd0);
        check_eq("t4_rst_max",   32'(ifa.res_max), 32'd0);
        check_eq("t4_rst_count", 32'(ifa.res_count), 32'd0);
        check_eq("t4_rst_busy",  32'(busy_a), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run_group_a("t4_post_rst", 12'h005, 12'h005, 12'h005, 12'h005, 14'h0014, 12'h005);
        run_group_a("t4_g2", 12'h123, 12'h456, 12'h789, 12'hABC, 14'h17BE, 12'hABC);
        run_group_a("t4_g3", 12'h000, 12'h000, 12'h000, 12'h001, 14'h0001, 12'h001);
`ifdef DRAIN_STATS_EN
        check_eq("stat_words",  stat_words_a, 32'd12);
        check_eq("stat_groups", 32'(stat_groups_a), 32'd3);
`endif

        // RD_LATENCY=2 with empty toggling every cycle, 50 groups, random backpressure
        fork
            begin
                for (int g = 0; g < 50; g++) begin
                    logic [13:0] s;
                    logic [11:0] m;
                    logic [11:0] w;
                    s = '0;
                    m = '0;
                    for (int k = 0; k < 4; k++) begin
                        w = (g == 0) ? 12'hFFF : 12'($urandom_range(0, 4095));
                        s = s + 14'(w);
                        if (w > m) m = w;
                        pdata_b = w;
                        push_b  = 1'b1;
                        @(negedge clk);
                    end
                    exp_sum_b.push_back(s);
                    exp_max_b.push_back(m);
                end
                push_b = 1'b0;
            end
            begin
                for (int c = 0; c < 4000 && n_res_b < 50; c++) begin
                    @(negedge clk);
                    ifb.res_ready = 1'($urandom_range(0, 1));
                    if (ifb.res_valid && ifb.res_ready) begin
                        if (exp_sum_b.size() == 0) begin
                            check_eq("t5_unexpected_result", 32'd1, 32'd0);
                        end else begin
                            check_eq("t5_sum",   32'(ifb.res_sum), 32'(exp_sum_b.pop_front()));
                            check_eq("t5_max",   32'(ifb.res_max), 32'(exp_max_b.pop_front()));
                            check_eq("t5_count", 32'(ifb.res_count), 32'd4);
                        end
                        n_res_b++;
                    end
                end
            end
        join
        check_eq("t5_groups",      32'(n_res_b), 32'd50);
        check_eq("t5_pops",        32'(pops_b), 32'd200);
        check_eq("underflow_a",    32'(underflow_a), 32'd0);
        check_eq("underflow_b",    32'(underflow_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
